// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction buffer between the fetch stage and the pre-decode stage.
//
// The fetch stage presents up to FETCH_WIDTH lanes per cycle. Each lane carries
// a PC, an instruction word and a packed branch-prediction record. The valid
// lanes need not be contiguous. They are packed together in lane order and
// written into a circular buffer. Pre-decode sees up to DECODE_WIDTH in-order
// head entries each cycle.
//
// A group of input lanes is accepted whole or rejected whole. When the group
// does not fit in the free space at the start of the cycle, fetch_stall_req is
// raised and fetch must present the same group again.
//
// Optional feature (compile-time macro FETCH_QUEUE_BYPASS_EN):
//   When the queue is empty and pre-decode is not stalled, up to DECODE_WIDTH
//   of the packed input lanes go straight to the outputs in the same cycle.
//   Only the lanes that were not forwarded are stored.
//   Without the macro, an entry always becomes visible one cycle after it is
//   pushed.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   clear           pipeline flush; empties the queue, takes priority over all
//   in_valid        per-lane valid from fetch (FETCH_WIDTH)
//   in_pc           lane PCs (FETCH_WIDTH*PC_WIDTH)
//   in_insn         lane instruction words (FETCH_WIDTH*INSN_WIDTH)
//   in_brpred       lane prediction records (FETCH_WIDTH*BRPRED_WIDTH)
//   fetch_stall_req input group not accepted this cycle; fetch must hold it
//   dec_stall       pre-decode stalled; nothing consumed
//   out_valid       per-lane valid to pre-decode (DECODE_WIDTH)
//   out_pc          head PCs (DECODE_WIDTH*PC_WIDTH)
//   out_insn        head instruction words (DECODE_WIDTH*INSN_WIDTH)
//   out_brpred      head prediction records (DECODE_WIDTH*BRPRED_WIDTH)
//   occupancy       current entry count (registered)
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int PC_WIDTH     = 32,
    parameter int INSN_WIDTH   = 32,
    parameter int BRPRED_WIDTH = 45
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic [FETCH_WIDTH-1:0]               in_valid,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]      in_pc,
    input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]    in_insn,
    input  logic [FETCH_WIDTH*BRPRED_WIDTH-1:0]  in_brpred,
    output logic                                 fetch_stall_req,
    input  logic                                 dec_stall,
    output logic [DECODE_WIDTH-1:0]              out_valid,
    output logic [DECODE_WIDTH*PC_WIDTH-1:0]     out_pc,
    output logic [DECODE_WIDTH*INSN_WIDTH-1:0]   out_insn,
    output logic [DECODE_WIDTH*BRPRED_WIDTH-1:0] out_brpred,
    output logic [$clog2(DEPTH):0]               occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] DW_C    = CW'(DECODE_WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] head_q,  head_d;
    logic [PW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;

    // Storage contents are don't-care after reset, so they carry no reset.
    logic [PC_WIDTH-1:0]     pc_mem     [DEPTH];
    logic [INSN_WIDTH-1:0]   insn_mem   [DEPTH];
    logic [BRPRED_WIDTH-1:0] brpred_mem [DEPTH];

    // ------------------------------------------------------------------
    // Input packing: lane_pos[i] is the number of valid lanes below lane i.
    // This is the offset that lane i takes in the packed group.
    // ------------------------------------------------------------------
    logic [CW-1:0] lane_pos [FETCH_WIDTH];
    logic [CW-1:0] n_in;

    always_comb begin
        n_in = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_pos[i] = n_in;
            n_in        = n_in + CW'(in_valid[i]);
        end
    end

    // ------------------------------------------------------------------
    // Push / pop control
    // ------------------------------------------------------------------
    logic [CW-1:0] free_slots;
    logic          push_fits;
    logic          accept;
    logic          bypass_act;
    logic [CW-1:0] n_fwd;
    logic [CW-1:0] n_enq;
    logic [CW-1:0] n_out;

    // Free space comes only from the count at the start of the cycle.
    // Entries popped in the same cycle do not make room for this push.
    assign free_slots      = DEPTH_C - count_q;
    assign push_fits       = (n_in <= free_slots);
    assign accept          = push_fits && !clear;
    assign fetch_stall_req = !push_fits && !clear;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_act = (count_q == '0) && !dec_stall && !clear;
`else
    assign bypass_act = 1'b0;
`endif

    // Packed lanes below n_fwd go straight to the outputs. The rest are stored.
    assign n_fwd = bypass_act ? ((n_in < DW_C) ? n_in : DW_C) : '0;
    assign n_enq = accept ? (n_in - n_fwd) : '0;
    assign n_out = (!dec_stall && !clear) ? ((count_q < DW_C) ? count_q : DW_C) : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(n_out);
            tail_d  = tail_q + PW'(n_enq);
            count_d = count_q + n_enq - n_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign occupancy = count_q;

    // ------------------------------------------------------------------
    // Storage write: each stored lane goes to tail + (packed offset - n_fwd)
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_addr [FETCH_WIDTH];

    genvar gi;
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr_addr
        assign wr_addr[gi] = tail_q + PW'(lane_pos[gi] - n_fwd);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (accept && in_valid[i] && (lane_pos[i] >= n_fwd)) begin
                pc_mem[wr_addr[i]]     <= in_pc[i*PC_WIDTH +: PC_WIDTH];
                insn_mem[wr_addr[i]]   <= in_insn[i*INSN_WIDTH +: INSN_WIDTH];
                brpred_mem[wr_addr[i]] <= in_brpred[i*BRPRED_WIDTH +: BRPRED_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output lanes: head + i from storage, or packed input lane i when the
    // bypass is active.
    // ------------------------------------------------------------------
    for (gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
        logic [PW-1:0]           rd_addr;
        logic [PC_WIDTH-1:0]     byp_pc;
        logic [INSN_WIDTH-1:0]   byp_insn;
        logic [BRPRED_WIDTH-1:0] byp_brpred;

        assign rd_addr = head_q + PW'(gi);

        // Find the input lane whose packed offset equals this output lane.
        always_comb begin
            byp_pc     = '0;
            byp_insn   = '0;
            byp_brpred = '0;
            for (int l = 0; l < FETCH_WIDTH; l++) begin
                if (in_valid[l] && (lane_pos[l] == CW'(gi))) begin
                    byp_pc     = in_pc[l*PC_WIDTH +: PC_WIDTH];
                    byp_insn   = in_insn[l*INSN_WIDTH +: INSN_WIDTH];
                    byp_brpred = in_brpred[l*BRPRED_WIDTH +: BRPRED_WIDTH];
                end
            end
        end

        assign out_valid[gi] = bypass_act ? (CW'(gi) < n_fwd)
                                          : ((CW'(gi) < count_q) && !clear);
        assign out_pc[gi*PC_WIDTH +: PC_WIDTH] =
            bypass_act ? byp_pc : pc_mem[rd_addr];
        assign out_insn[gi*INSN_WIDTH +: INSN_WIDTH] =
            bypass_act ? byp_insn : insn_mem[rd_addr];
        assign out_brpred[gi*BRPRED_WIDTH +: BRPRED_WIDTH] =
            bypass_act ? byp_brpred : brpred_mem[rd_addr];
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue.
//
// A reference queue of expected entries is updated every cycle from the
// driven stimulus. The DUT outputs are sampled 1 ns after the falling edge.
// On every cycle the bench compares out_valid, fetch_stall_req, occupancy and
// each valid payload lane against that reference queue.
//
// A table of hand-computed vectors also carries the expected out_valid,
// fetch_stall_req and occupancy for each cycle. Those expectations assume the
// default build, where the bypass is not compiled in.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 8;
    localparam int PCW   = 32;
    localparam int IW    = 32;
    localparam int BPW   = 45;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [FW-1:0]     in_valid;
    logic [FW*PCW-1:0] in_pc;
    logic [FW*IW-1:0]  in_insn;
    logic [FW*BPW-1:0] in_brpred;
    logic              fetch_stall_req;
    logic              dec_stall;
    logic [DW-1:0]     out_valid;
    logic [DW*PCW-1:0] out_pc;
    logic [DW*IW-1:0]  out_insn;
    logic [DW*BPW-1:0] out_brpred;
    logic [3:0]        occupancy;

    always #5 clk = ~clk;

    fetch_queue #(
        .FETCH_WIDTH (FW),
        .DECODE_WIDTH(DW),
        .DEPTH       (DEPTH),
        .PC_WIDTH    (PCW),
        .INSN_WIDTH  (IW),
        .BRPRED_WIDTH(BPW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_insn        (in_insn),
        .in_brpred      (in_brpred),
        .fetch_stall_req(fetch_stall_req),
        .dec_stall      (dec_stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .out_brpred     (out_brpred),
        .occupancy      (occupancy)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [44:0] bp;
    } ent_t;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] p0;
        logic [31:0] p1;
        logic        ds;
        logic        cl;
        logic [1:0]  ov;
        logic        fsr;
        logic [3:0]  occ;
    } vec_t;

    ent_t mq[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // The instruction word and prediction record are derived from the PC.
    // Each lane therefore carries a distinct payload, and a swapped lane shows up.
    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.insn = ~pc ^ 32'h0F0F_0000;
        e.bp   = {pc[12:0], pc} ^ 45'h155;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic ds, input logic cl,
                       input logic [1:0] ov, input logic fsr, input logic [3:0] occ);
        vec_t t;
        t.v = v; t.p0 = p0; t.p1 = p1; t.ds = ds; t.cl = cl;
        t.ov = ov; t.fsr = fsr; t.occ = occ;
        vecs.push_back(t);
    endtask

    // Drive one cycle of stimulus, compare against the reference queue, then
    // advance the reference queue to the state it will have after the next
    // rising edge.
    task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic ds, input logic cl,
                        output logic [1:0] ov_s, output logic fsr_s, output logic [3:0] occ_s);
        ent_t       lanes[$];
        ent_t       e0, e1, exp_e;
        int         sz, n_in, nfwd, npop;
        bit         byp;
        logic [1:0] exp_ov;
        @(negedge clk);
        e0 = mk(p0);
        e1 = mk(p1);
        in_valid  = v;
        in_pc     = {e1.pc, e0.pc};
        in_insn   = {e1.insn, e0.insn};
        in_brpred = {e1.bp, e0.bp};
        dec_stall = ds;
        clear     = cl;
        #1;
        ov_s  = out_valid;
        fsr_s = fetch_stall_req;
        occ_s = occupancy;
        sz = mq.size();
        if (v[0]) lanes.push_back(e0);
        if (v[1]) lanes.push_back(e1);
        n_in = lanes.size();
        byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sz == 0) && !ds && !cl;
`endif
        nfwd = byp ? ((n_in < DW) ? n_in : DW) : 0;
        for (int j = 0; j < DW; j++)
            exp_ov[j] = byp ? (j < nfwd) : (!cl && (j < sz));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("fetch_stall_req", 64'(fetch_stall_req), 64'(!cl && (n_in > DEPTH - sz)));
        chk("occupancy", 64'(occupancy), 64'(sz));
        for (int j = 0; j < DW; j++) begin
            if (exp_ov[j]) begin
                exp_e = byp ? lanes[j] : mq[j];
                chk($sformatf("out_pc[%0d]", j), 64'(out_pc[j*PCW +: PCW]), 64'(exp_e.pc));
                chk($sformatf("out_insn[%0d]", j), 64'(out_insn[j*IW +: IW]), 64'(exp_e.insn));
                chk($sformatf("out_brpred[%0d]", j), 64'(out_brpred[j*BPW +: BPW]), 64'(exp_e.bp));
            end
        end
        $display("cyc v=%b ds=%b cl=%b sz=%0d -> ov=%b fsr=%b occ=%0d pc0=%h pc1=%h",
                 v, ds, cl, sz, out_valid, fetch_stall_req, occupancy,
                 out_pc[31:0], out_pc[63:32]);
        if (cl) begin
            mq.delete();
        end else begin
            if (!ds && !byp) begin
                npop = (sz < DW) ? sz : DW;
                repeat (npop) void'(mq.pop_front());
            end
            if (n_in <= DEPTH - sz)
                for (int k = nfwd; k < n_in; k++) mq.push_back(lanes[k]);
        end
    endtask

    initial begin
        logic [1:0]  ov;
        logic        fsr;
        logic [3:0]  occ;
        logic [31:0] pcn;

        rst_n = 1'b0; clear = 1'b0; dec_stall = 1'b0;
        in_valid = '0; in_pc = '0; in_insn = '0; in_brpred = '0;
        #2;
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_fetch_stall_req", 64'(fetch_stall_req), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // v, pc0, pc1, dec_stall, clear | out_valid, fetch_stall_req, occupancy
        // Push held by one stall cycle, then consumed.
        add(2'b11, 32'h1000, 32'h1004, 1, 0, 2'b00, 0, 4'd0);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd2);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b00, 0, 4'd0);
        // Only lane 1 valid: it becomes output lane 0.
        add(2'b10, 32'hDEAD0000, 32'h2004, 0, 0, 2'b00, 0, 4'd0);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b01, 0, 4'd1);
        // Fill to full under stall; reject; no pop credit on release.
        add(2'b11, 32'h3000, 32'h3004, 1, 0, 2'b00, 0, 4'd0);
        add(2'b11, 32'h3008, 32'h300c, 1, 0, 2'b11, 0, 4'd2);
        add(2'b11, 32'h3010, 32'h3014, 1, 0, 2'b11, 0, 4'd4);
        add(2'b11, 32'h3018, 32'h301c, 1, 0, 2'b11, 0, 4'd6);
        add(2'b11, 32'h3020, 32'h3024, 1, 0, 2'b11, 1, 4'd8);
        add(2'b11, 32'h3020, 32'h3024, 0, 0, 2'b11, 1, 4'd8);
        add(2'b11, 32'h3020, 32'h3024, 0, 0, 2'b11, 0, 4'd6);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd6);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd4);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd2);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b00, 0, 4'd0);
        // Clear with count 6 and a same-cycle push.
        add(2'b11, 32'h4000, 32'h4004, 1, 0, 2'b00, 0, 4'd0);
        add(2'b11, 32'h4008, 32'h400c, 1, 0, 2'b11, 0, 4'd2);
        add(2'b11, 32'h4010, 32'h4014, 1, 0, 2'b11, 0, 4'd4);
        add(2'b11, 32'h4018, 32'h401c, 1, 1, 2'b00, 0, 4'd6);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b00, 0, 4'd0);
        // Clear while full: the stall request must stay low.
        add(2'b11, 32'h5000, 32'h5004, 1, 0, 2'b00, 0, 4'd0);
        add(2'b11, 32'h5008, 32'h500c, 1, 0, 2'b11, 0, 4'd2);
        add(2'b11, 32'h5010, 32'h5014, 1, 0, 2'b11, 0, 4'd4);
        add(2'b11, 32'h5018, 32'h501c, 1, 0, 2'b11, 0, 4'd6);
        add(2'b11, 32'h5020, 32'h5024, 0, 1, 2'b00, 0, 4'd8);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b00, 0, 4'd0);
        // Full with a single lane: no stall for an empty group, stall for one lane.
        add(2'b11, 32'h6000, 32'h6004, 1, 0, 2'b00, 0, 4'd0);
        add(2'b11, 32'h6008, 32'h600c, 1, 0, 2'b11, 0, 4'd2);
        add(2'b11, 32'h6010, 32'h6014, 1, 0, 2'b11, 0, 4'd4);
        add(2'b11, 32'h6018, 32'h601c, 1, 0, 2'b11, 0, 4'd6);
        add(2'b00, 32'h0,    32'h0,    1, 0, 2'b11, 0, 4'd8);
        add(2'b01, 32'h6020, 32'hDEAD0000, 1, 0, 2'b11, 1, 4'd8);
        add(2'b01, 32'h6020, 32'hDEAD0000, 0, 0, 2'b11, 1, 4'd8);
        add(2'b01, 32'h6020, 32'hDEAD0000, 0, 0, 2'b11, 0, 4'd6);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd5);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b11, 0, 4'd3);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b01, 0, 4'd1);
        add(2'b00, 32'h0,    32'h0,    0, 0, 2'b00, 0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].p0, vecs[i].p1, vecs[i].ds, vecs[i].cl, ov, fsr, occ);
`ifndef FETCH_QUEUE_BYPASS_EN
            chk($sformatf("vec%0d_out_valid", i), 64'(ov), 64'(vecs[i].ov));
            chk($sformatf("vec%0d_fetch_stall_req", i), 64'(fsr), 64'(vecs[i].fsr));
            chk($sformatf("vec%0d_occupancy", i), 64'(occ), 64'(vecs[i].occ));
`endif
        end

        // Push into an empty, unstalled queue (same-cycle output when bypass is built in).
        step(2'b11, 32'h8000, 32'h8004, 0, 0, ov, fsr, occ);
        step(2'b01, 32'h8008, 32'h0,    0, 0, ov, fsr, occ);
        repeat (3) step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);

        // Move head to index 6, then stream across the 7 -> 0 wrap.
        step(2'b00, 32'h0, 32'h0, 0, 1, ov, fsr, occ);
        step(2'b11, 32'h9000, 32'h9004, 1, 0, ov, fsr, occ);
        step(2'b11, 32'h9008, 32'h900c, 1, 0, ov, fsr, occ);
        step(2'b11, 32'h9010, 32'h9014, 1, 0, ov, fsr, occ);
        repeat (3) step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);
        pcn = 32'h9100;
        for (int i = 0; i < 20; i++) begin
            step(2'b11, pcn, pcn + 32'd4, 0, 0, ov, fsr, occ);
            pcn = pcn + 32'd8;
        end

        // Random mix of lane patterns, stalls and flushes.
        pcn = 32'hA000;
        for (int i = 0; i < 60; i++) begin
            step(2'($urandom_range(0, 3)), pcn, pcn + 32'd4,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), ov, fsr, occ);
            pcn = pcn + 32'd8;
        end
        repeat (5) step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);

        // Reset mid-stream with five entries held.
        step(2'b00, 32'h0, 32'h0, 0, 1, ov, fsr, occ);
        step(2'b11, 32'hB000, 32'hB004, 1, 0, ov, fsr, occ);
        step(2'b11, 32'hB008, 32'hB00c, 1, 0, ov, fsr, occ);
        step(2'b01, 32'hB010, 32'h0,    1, 0, ov, fsr, occ);
        @(negedge clk);
        in_valid  = 2'b11;
        dec_stall = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midreset_occupancy", 64'(occupancy), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_fetch_stall_req", 64'(fetch_stall_req), 64'd0);
        $display("reset asserted mid-stream -> ov=%b fsr=%b occ=%0d",
                 out_valid, fetch_stall_req, occupancy);
        mq.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 2'b00;
        step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);
        step(2'b11, 32'hC000, 32'hC004, 1, 0, ov, fsr, occ);
        step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);
        step(2'b00, 32'h0, 32'h0, 0, 0, ov, fsr, occ);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the pre-decode stage.
- Accepts up to FETCH_WIDTH fetched lanes per cycle: PC, instruction word and branch-prediction record.
- Compacts the valid lanes and presents up to DECODE_WIDTH in-order entries per cycle downstream.
- Decouples i-cache-miss bubbles from decode stalls; backpressures fetch through a stall request.

Parameters:
FETCH_WIDTH, 2, lanes written per cycle
DECODE_WIDTH, 2, lanes read per cycle
DEPTH, 8, entries; power of two, DEPTH >= FETCH_WIDTH + DECODE_WIDTH
PC_WIDTH, 32, PC bits
INSN_WIDTH, 32, instruction bits
BRPRED_WIDTH, 45, packed branch-prediction record: predAddr, predTaken, globalHistory, phtPrevValue

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  pipeline flush (branch recovery); empties queue
in_valid  in  FETCH_WIDTH  per-lane valid from fetch stage
in_pc  in  FETCH_WIDTH*PC_WIDTH  lane PCs
in_insn  in  FETCH_WIDTH*INSN_WIDTH  lane instruction words
in_brpred  in  FETCH_WIDTH*BRPRED_WIDTH  lane prediction records
fetch_stall_req  out  1  high: this cycle's input group is not accepted; fetch must hold it
dec_stall  in  1  pre-decode stalled; no entries consumed
out_valid  out  DECODE_WIDTH  per-lane valid to pre-decode
out_pc  out  DECODE_WIDTH*PC_WIDTH  head PCs
out_insn  out  DECODE_WIDTH*INSN_WIDTH  head instruction words
out_brpred  out  DECODE_WIDTH*BRPRED_WIDTH  head prediction records
occupancy  out  log2(DEPTH)+1  current entry count

Behaviour:
- Reset (rst_n low, asynchronous):
  - head, tail, count = 0; storage contents are don't-care.
  - out_valid = 0, fetch_stall_req = 0, occupancy = 0.
  - Reset deasserted mid-stream: queue restarts empty; no entry survives.
- Circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus an explicit count register.
- Push:
  - n_in = popcount(in_valid). Lanes need not be a contiguous prefix.
  - Valid lanes are compacted in lane order and written to tail .. tail+n_in-1 (mod DEPTH); tail += n_in.
  - Accept is all-or-nothing: accepted iff n_in <= DEPTH - count, using count at start of cycle; same-cycle pops are not credited.
  - fetch_stall_req = (n_in > DEPTH - count) && !clear; combinational. Not asserted when n_in = 0.
  - Rejected group is not written; fetch re-presents it next cycle.
- Pop:
  - out_valid[i] = (i < count) && !clear. Payload lane i = entry head+i (mod DEPTH).
  - Output is from storage, so push-to-visible latency is 1 cycle.
  - If !dec_stall && !clear: n_out = min(count, DECODE_WIDTH); head += n_out.
  - If dec_stall: outputs hold stable and nothing is consumed.
- Simultaneous push and pop: count_next = count + n_acc - n_out. Never exceeds DEPTH and never goes below 0.
- Full (count = DEPTH): any non-empty input gives fetch_stall_req = 1.
- Empty (count = 0): out_valid = 0.
- Clear: highest priority.
  - Next cycle head = tail = count = 0.
  - Same-cycle push is discarded; same-cycle outputs are gated invalid.
  - fetch_stall_req = 0 during the clear cycle.
- occupancy = count register, registered.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined:
  - When count = 0, !dec_stall and !clear, up to DECODE_WIDTH compacted input lanes drive the outputs combinationally in the same cycle.
  - Those lanes are not written; only the remainder (n_in - forwarded) is enqueued.
  - Latency is 0 cycles in that case.
- Undefined: no bypass; latency is always 1 cycle.

Test Plan:
1. Reset while count=5 -> next cycle occupancy=0, out_valid=00, fetch_stall_req=0.
2. Push in_valid=11, PCs 0x1000/0x1004, dec_stall=1 for 1 cycle, then release -> cycle+1 out_valid=11, out_pc 0x1000/0x1004; head advances after release; occupancy 2->0.
3. Push in_valid=10 (lane1 only, PC 0x2004) -> stored at entry 0; output lane0 pc=0x2004, out_valid=01.
4. dec_stall=1, push 11 for 4 cycles -> occupancy 8; 5th push gives fetch_stall_req=1 and occupancy stays 8. Release stall with push 11 still pending -> still rejected that cycle (no pop credit); accepted next cycle, occupancy 6 -> 6.
5. Wrap-around: 20 cycles of push 11 and pop 2 with head starting at 6 -> PCs emerge strictly in order across the index 7->0 wrap.
6. clear asserted with count=6 and push 11 -> same cycle out_valid=00, fetch_stall_req=0; next cycle occupancy=0.
   - With FETCH_QUEUE_BYPASS_EN, empty queue, push 11 -> out_valid=11 in the same cycle and occupancy stays 0.
